// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, load/store and backing-memory signals shared by the
// arbiter and its neighbours. The slave view belongs to the arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// load/store. Data wins by default; a streak limit guarantees fetch progress.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LAT      = 2,
  parameter int MAX_D_STREAK = 4
) (
  input logic              clk,
  input logic              n_rst,
  mem_port_arbiter_if.slave bus
);
  localparam int CNT_W    = 3;
  localparam int STREAK_W = (MAX_D_STREAK < 1) ? 1 : $clog2(MAX_D_STREAK + 1);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic {OWN_I, OWN_D} owner_t;

  state_t              state;
  owner_t              owner;
  logic                owner_we;
  logic [CNT_W-1:0]    cnt;
  logic [STREAK_W-1:0] streak;

  logic              pick_d;
  logic              grant_i;
  logic              grant_d;
  logic              done;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  // Fetch is forced only when it is actually contending and the streak is spent.
  assign pick_d  = bus.d_req && !(bus.if_req && streak == STREAK_W'(MAX_D_STREAK));
  // Grants are combinational from the requests, so they are held low while reset is asserted.
  assign grant_d = n_rst && (state == IDLE) && pick_d;
  assign grant_i = n_rst && (state == IDLE) && bus.if_req && !pick_d;
  assign done    = (state == WAIT) && (cnt == CNT_W'(1));

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    addr_mux    = '0;
    wdata_mux   = '0;
    bus.mem_we  = 1'b0;
    if (grant_d) begin
      addr_mux   = bus.d_addr;
      wdata_mux  = bus.d_wdata;
      bus.mem_we = bus.d_we;
    end else if (grant_i) begin
      addr_mux   = bus.if_addr;
    end
  end

  assign bus.mem_en    = grant_i || grant_d;
  assign bus.mem_addr  = addr_mux;
  assign bus.mem_wdata = wdata_mux;
  assign bus.if_gnt    = grant_i;
  assign bus.d_gnt     = grant_d;
  assign bus.busy      = (state == WAIT);

  assign bus.if_rvalid = done && (owner == OWN_I);
  assign bus.d_rvalid  = done && (owner == OWN_D);
  assign bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : '0;
  assign bus.d_rdata   = (bus.d_rvalid && !owner_we) ? bus.mem_rdata : '0;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= IDLE;
      owner    <= OWN_I;
      owner_we <= 1'b0;
      cnt      <= '0;
      streak   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_i || grant_d) begin
            state    <= WAIT;
            cnt      <= CNT_W'(MEM_LAT);
            owner    <= grant_d ? OWN_D : OWN_I;
            owner_we <= grant_d && bus.d_we;
            if (grant_i)
              streak <= '0;
            else if (bus.if_req)
              streak <= streak + STREAK_W'(1);
          end
        end
        WAIT: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1))
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one MEM_LAT=2 instance for most
// scenarios and one MEM_LAT=1 instance for the peak-throughput case.
module tb_mem_port_arbiter;
  logic clk   = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .MAX_D_STREAK(4)) dut2 (
    .clk(clk), .n_rst(n_rst), .bus(b2.slave)
  );
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_D_STREAK(4)) dut1 (
    .clk(clk), .n_rst(n_rst), .bus(b1.slave)
  );

  // Memory contents are a fixed function of the address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return (a == 32'h10) ? 32'hDEAD_BEEF : {a[15:0] ^ 16'h5A5A, a[15:0]};
  endfunction

  // Backing memory models: data appears MEM_LAT cycles after mem_en. They are
  // not reset and answer stores too, so the DUT must gate rdata itself.
  logic        v2a = 1'b0, v2b = 1'b0, v1a = 1'b0;
  logic [31:0] a2a = '0, a2b = '0, a1a = '0;
  always @(posedge clk) begin
    v2a <= b2.mem_en; a2a <= b2.mem_addr;
    v2b <= v2a;       a2b <= a2a;
    v1a <= b1.mem_en; a1a <= b1.mem_addr;
  end
  assign b2.mem_rdata = v2b ? mem_fn(a2b) : '0;
  assign b1.mem_rdata = v1a ? mem_fn(a1a) : '0;

  // Requesters must hold request and address until granted.
  logic        if_pend = 1'b0, d_pend = 1'b0;
  logic [31:0] if_a_q = '0, d_a_q = '0;
  always @(posedge clk) begin
    if (n_rst && if_pend)
      assert (b2.if_req && b2.if_addr == if_a_q) else $error("if_req dropped before if_gnt");
    if (n_rst && d_pend)
      assert (b2.d_req && b2.d_addr == d_a_q) else $error("d_req dropped before d_gnt");
    if_pend <= n_rst && b2.if_req && !b2.if_gnt;
    d_pend  <= n_rst && b2.d_req && !b2.d_gnt;
    if_a_q  <= b2.if_addr;
    d_a_q   <= b2.d_addr;
  end

  task automatic test_reset();
    b2.if_req = 0; b2.if_addr = '0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = '0; b2.d_wdata = '0;
    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    n_rst = 0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if ({b2.if_gnt, b2.if_rvalid, b2.if_rdata, b2.d_gnt, b2.d_rvalid, b2.d_rdata, b2.mem_en,
         b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.busy} !== '0) begin
      n_fail++; $display("FAIL reset_outputs: busy=%b mem_en=%b (required all 0)", b2.busy, b2.mem_en);
    end
    @(negedge clk); n_rst = 1; #1;
    n_checks++;
    if ({b2.busy, b2.mem_en, b1.busy, b1.mem_en} !== 4'b0) begin
      n_fail++; $display("FAIL reset_release_idle: got %b required 0000", {b2.busy, b2.mem_en, b1.busy, b1.mem_en});
    end
  endtask

  task automatic test_fetch();
    @(negedge clk); b2.if_req = 1; b2.if_addr = 32'h10; #1;
    n_checks++;
    if ({b2.if_gnt, b2.d_gnt, b2.mem_en, b2.mem_we, b2.busy} !== 5'b10100 || b2.mem_addr !== 32'h10 || b2.mem_wdata !== '0) begin
      n_fail++; $display("FAIL fetch_grant: gnt/dgnt/en/we/busy=%b addr=%h required 10100 addr=00000010",
                         {b2.if_gnt, b2.d_gnt, b2.mem_en, b2.mem_we, b2.busy}, b2.mem_addr);
    end
    @(negedge clk); b2.if_req = 0; #1;
    n_checks++;
    if ({b2.if_gnt, b2.mem_en, b2.if_rvalid, b2.busy} !== 4'b0001) begin
      n_fail++; $display("FAIL fetch_t1: gnt/en/rvalid/busy=%b required 0001", {b2.if_gnt, b2.mem_en, b2.if_rvalid, b2.busy});
    end
    @(negedge clk); #1;
    n_checks++;
    if ({b2.if_rvalid, b2.busy, b2.d_rvalid} !== 3'b110 || b2.if_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL fetch_t2: rvalid/busy/d_rvalid=%b rdata=%h required 110 rdata=deadbeef",
                         {b2.if_rvalid, b2.busy, b2.d_rvalid}, b2.if_rdata);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({b2.if_rvalid, b2.busy} !== 2'b00 || b2.if_rdata !== '0) begin
      n_fail++; $display("FAIL fetch_t3: rvalid/busy=%b rdata=%h required 00 rdata=0", {b2.if_rvalid, b2.busy}, b2.if_rdata);
    end
  endtask

  task automatic test_contended_pair();
    @(negedge clk);
    b2.if_req = 1; b2.if_addr = 32'h80; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h40; #1;
    n_checks++;
    if ({b2.d_gnt, b2.if_gnt} !== 2'b10 || b2.mem_addr !== 32'h40) begin
      n_fail++; $display("FAIL pair_d_first: d_gnt/if_gnt=%b addr=%h required 10 addr=00000040", {b2.d_gnt, b2.if_gnt}, b2.mem_addr);
    end
    @(negedge clk); b2.d_req = 0; #1;
    @(negedge clk); #1;
    n_checks++;
    if ({b2.d_rvalid, b2.if_rvalid, b2.if_gnt} !== 3'b100 || b2.d_rdata !== mem_fn(32'h40)) begin
      n_fail++; $display("FAIL pair_d_rvalid: d_rv/if_rv/if_gnt=%b d_rdata=%h required 100 d_rdata=%h",
                         {b2.d_rvalid, b2.if_rvalid, b2.if_gnt}, b2.d_rdata, mem_fn(32'h40));
    end
    @(negedge clk); #1;
    n_checks++;
    if ({b2.if_gnt, b2.d_gnt} !== 2'b10 || b2.mem_addr !== 32'h80) begin
      n_fail++; $display("FAIL pair_i_at_t3: if_gnt/d_gnt=%b addr=%h required 10 addr=00000080", {b2.if_gnt, b2.d_gnt}, b2.mem_addr);
    end
    @(negedge clk); b2.if_req = 0;
    @(negedge clk); #1;
    n_checks++;
    if (b2.if_rvalid !== 1'b1 || b2.if_rdata !== mem_fn(32'h80)) begin
      n_fail++; $display("FAIL pair_i_rvalid: rvalid=%b rdata=%h required 1 rdata=%h", b2.if_rvalid, b2.if_rdata, mem_fn(32'h80));
    end
  endtask

  task automatic test_streak();
    string seq;
    logic  exp_ig, exp_dg, own_i;
    seq = "DDDDIDDDDID";
    @(negedge clk);
    b2.if_req = 1; b2.if_addr = 32'h100; b2.d_req = 1; b2.d_we = 0; b2.d_addr = 32'h200;
    for (int k = 0; k <= 30; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_ig = (k % 3 == 0) && (seq[k/3] == "I");
      exp_dg = (k % 3 == 0) && (seq[k/3] == "D");
      n_checks++;
      if ({b2.if_gnt, b2.d_gnt} !== {exp_ig, exp_dg}) begin
        n_fail++; $display("FAIL streak_grant cycle %0d: if_gnt/d_gnt=%b required %b", k, {b2.if_gnt, b2.d_gnt}, {exp_ig, exp_dg});
      end
      if (k % 3 == 2) begin
        own_i = (seq[k/3] == "I");
        n_checks++;
        if ({b2.if_rvalid, b2.d_rvalid} !== {own_i, !own_i} ||
            b2.if_rdata !== (own_i ? mem_fn(32'h100) : 32'h0) ||
            b2.d_rdata  !== (own_i ? 32'h0 : mem_fn(32'h200))) begin
          n_fail++; $display("FAIL streak_resp cycle %0d: rv=%b if_rdata=%h d_rdata=%h required rv=%b",
                             k, {b2.if_rvalid, b2.d_rvalid}, b2.if_rdata, b2.d_rdata, {own_i, !own_i});
        end
      end
    end
    @(negedge clk); b2.d_req = 0;
    @(negedge clk);
    @(negedge clk); #1;
    n_checks++;
    if ({b2.if_gnt, b2.d_gnt} !== 2'b10) begin
      n_fail++; $display("FAIL streak_tail_fetch: if_gnt/d_gnt=%b required 10", {b2.if_gnt, b2.d_gnt});
    end
    @(negedge clk); b2.if_req = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store();
    @(negedge clk);
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h8; b2.d_wdata = 32'h5; #1;
    n_checks++;
    if ({b2.d_gnt, b2.mem_en, b2.mem_we} !== 3'b111 || b2.mem_addr !== 32'h8 || b2.mem_wdata !== 32'h5) begin
      n_fail++; $display("FAIL store_grant: gnt/en/we=%b addr=%h wdata=%h required 111 addr=00000008 wdata=00000005",
                         {b2.d_gnt, b2.mem_en, b2.mem_we}, b2.mem_addr, b2.mem_wdata);
    end
    @(negedge clk); b2.d_req = 0; b2.d_we = 0; b2.d_wdata = '0;
    @(negedge clk); #1;
    n_checks++;
    if ({b2.d_rvalid, b2.if_rvalid} !== 2'b10 || b2.d_rdata !== '0) begin
      n_fail++; $display("FAIL store_complete: d_rv/if_rv=%b d_rdata=%h required 10 d_rdata=0", {b2.d_rvalid, b2.if_rvalid}, b2.d_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    @(negedge clk); b2.if_req = 1; b2.if_addr = 32'h20; #1;
    n_checks++;
    if (b2.if_gnt !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_grant: if_gnt=%b required 1", b2.if_gnt);
    end
    @(negedge clk); b2.if_req = 0; n_rst = 0; #1;
    n_checks++;
    if ({b2.if_gnt, b2.if_rvalid, b2.if_rdata, b2.d_gnt, b2.d_rvalid, b2.d_rdata, b2.mem_en,
         b2.mem_we, b2.mem_addr, b2.mem_wdata, b2.busy} !== '0) begin
      n_fail++; $display("FAIL rst_mid_outputs: busy=%b mem_en=%b required 0", b2.busy, b2.mem_en);
    end
    b2.if_req = 1; b2.if_addr = 32'h24; #1;
    n_checks++;
    if ({b2.if_gnt, b2.mem_en, b2.mem_addr} !== '0) begin
      n_fail++; $display("FAIL rst_mid_no_grant: if_gnt=%b mem_en=%b required 0", b2.if_gnt, b2.mem_en);
    end
    @(negedge clk); #1;
    n_checks++;
    if ({b2.if_rvalid, b2.if_rdata, b2.busy} !== '0) begin
      n_fail++; $display("FAIL rst_mid_no_rvalid: rvalid=%b rdata=%h busy=%b required 0", b2.if_rvalid, b2.if_rdata, b2.busy);
    end
    @(negedge clk); n_rst = 1; #1;
    n_checks++;
    if ({b2.if_gnt, b2.mem_en} !== 2'b11 || b2.mem_addr !== 32'h24) begin
      n_fail++; $display("FAIL rst_release_grant: gnt/en=%b addr=%h required 11 addr=00000024", {b2.if_gnt, b2.mem_en}, b2.mem_addr);
    end
    @(negedge clk); b2.if_req = 0;
    @(negedge clk); #1;
    n_checks++;
    if (b2.if_rvalid !== 1'b1 || b2.if_rdata !== mem_fn(32'h24)) begin
      n_fail++; $display("FAIL rst_release_rvalid: rvalid=%b rdata=%h required 1 rdata=%h", b2.if_rvalid, b2.if_rdata, mem_fn(32'h24));
    end
  endtask

  task automatic test_lat1_throughput();
    logic [31:0] a;
    @(negedge clk); b1.if_req = 1; b1.if_addr = 32'h300;
    for (int c = 0; c <= 9; c++) begin
      if (c > 0) @(negedge clk);
      a = 32'h300 + 32'(4 * (c / 2));
      #1;
      if (c % 2 == 0) begin
        n_checks++;
        if ({b1.if_gnt, b1.if_rvalid} !== 2'b10 || b1.mem_addr !== a) begin
          n_fail++; $display("FAIL lat1_grant cycle %0d: gnt/rv=%b addr=%h required 10 addr=%h", c, {b1.if_gnt, b1.if_rvalid}, b1.mem_addr, a);
        end
      end else begin
        n_checks++;
        if ({b1.if_gnt, b1.if_rvalid} !== 2'b01 || b1.if_rdata !== mem_fn(a)) begin
          n_fail++; $display("FAIL lat1_rvalid cycle %0d: gnt/rv=%b rdata=%h required 01 rdata=%h", c, {b1.if_gnt, b1.if_rvalid}, b1.if_rdata, mem_fn(a));
        end
        if (c == 9) b1.if_req = 0;
        else        b1.if_addr = a + 32'h4;
      end
    end
    @(negedge clk); #1;
    n_checks++;
    if ({b1.if_gnt, b1.if_rvalid, b1.busy} !== 3'b000) begin
      n_fail++; $display("FAIL lat1_idle: gnt/rv/busy=%b required 000", {b1.if_gnt, b1.if_rvalid, b1.busy});
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_contended_pair();
    test_streak();
    test_store();
    test_reset_mid();
    test_lat1_throughput();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
